canny_line_buffer: RTL and testbench

Single-line pixel store for the Canny edge pipeline. Holds one image row of IMAGE_WIDTH 8-bit pixels written in raster order, then replays them in the same order for downstream windowing (Gaussian/Sobel stages). Write and read sides have independent pointers, one clock, no flow-control flags.

---
 rtl/canny_line_buffer_pkg.sv | 16 +
 rtl/canny_line_buffer_if.sv | 25 ++
 rtl/canny_line_buffer.sv | 96 +++++++++
 tb/tb_canny_line_buffer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/canny_line_buffer_pkg.sv
// Shared types and sizing for the Canny line buffer.
// Row width, pixel type and pointer helpers.
package definitions_pkg;

  localparam int IMAGE_WIDTH = 512;
  localparam int PTR_W = $clog2(IMAGE_WIDTH);

  typedef logic [7:0] pixel_t;

  function automatic logic [PTR_W-1:0] wrap_inc(
    input logic [PTR_W-1:0] p
  );
    return (p == PTR_W'(IMAGE_WIDTH - 1)) ? '0 : p + 1'b1;
  endfunction

endpackage

// File: rtl/canny_line_buffer_if.sv
// Pixel write / read-advance bundle for the line buffer.
// master drives strobes and pixels, slave returns o_data.
interface canny_line_buffer_if;
  import definitions_pkg::*;

  pixel_t      i_data;
  logic        i_data_valid;
  logic        rd_data;
  logic [24:0] o_data;

  modport master (
    output i_data,
    output i_data_valid,
    output rd_data,
    input  o_data
  );

  modport slave (
    input  i_data,
    input  i_data_valid,
    input  rd_data,
    output o_data
  );

endinterface

// File: rtl/canny_line_buffer.sv
// One-row pixel store with independent write/read pointers.
// Optional 3-tap window output: LINE_BUFFER_WINDOW_EN.
module canny_line_buffer
  import definitions_pkg::*;
#(
  parameter int IMAGE_WIDTH = definitions_pkg::IMAGE_WIDTH
) (
  input logic                clk,
  input logic                rstN,
  canny_line_buffer_if.slave bus
);

  localparam int PW = $clog2(IMAGE_WIDTH);
  localparam logic [PW-1:0] LAST = PW'(IMAGE_WIDTH - 1);

  function automatic logic [PW-1:0] inc(
    input logic [PW-1:0] p
  );
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  pixel_t        mem_q [IMAGE_WIDTH];
  pixel_t        mem_d [IMAGE_WIDTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;

  // Next-state for storage and both pointers
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (bus.i_data_valid) begin
      mem_d[wr_ptr_q] = bus.i_data;
      wr_ptr_d        = inc(wr_ptr_q);
    end
    if (bus.rd_data) begin
      rd_ptr_d = inc(rd_ptr_q);
    end
  end

  // Storage and pointer registers, reset clears the row
  always_ff @(posedge clk) begin
    if (rstN) begin
      for (int i = 0; i < IMAGE_WIDTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

`ifdef LINE_BUFFER_WINDOW_EN
  localparam logic [PW:0] FULL = (PW+1)'(IMAGE_WIDTH);
  localparam logic [PW:0] THREE = (PW+1)'(3);

  logic [PW:0]   cnt_q, cnt_d;
  logic [PW-1:0] rd1, rd2;

  // Unconsumed-pixel count, saturating at one row
  always_comb begin
    cnt_d = cnt_q;
    unique case ({bus.i_data_valid, bus.rd_data})
      2'b10: if (cnt_q != FULL) cnt_d = cnt_q + 1'b1;
      2'b01: if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Count register
  always_ff @(posedge clk) begin
    if (rstN) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Window output: current pixel in the top byte
  always_comb begin
    rd1 = inc(rd_ptr_q);
    rd2 = inc(rd1);
    bus.o_data = {(cnt_q >= THREE),
                  mem_q[rd_ptr_q], mem_q[rd1], mem_q[rd2]};
  end
`else
  // Single-pixel output, zero-extended
  always_comb begin
    bus.o_data = {17'b0, mem_q[rd_ptr_q]};
  end
`endif

endmodule

// File: tb/tb_canny_line_buffer.sv
// Directed self-checking bench for canny_line_buffer.
// Define LINE_BUFFER_WINDOW_EN to also exercise window mode.
module tb_canny_line_buffer;
  import definitions_pkg::*;

  localparam int W = 512;

  logic clk;
  logic rstN;
  int   checks;
  int   errors;

  canny_line_buffer_if bus ();

  canny_line_buffer #(.IMAGE_WIDTH(W)) dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Current-pixel field in either output format
  function automatic logic [7:0] pix();
`ifdef LINE_BUFFER_WINDOW_EN
    return bus.o_data[23:16];
`else
    return bus.o_data[7:0];
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.i_data_valid = 1'b0;
    bus.rd_data      = 1'b0;
    bus.i_data       = 8'h00;
  endtask

  task automatic do_reset();
    idle();
    rstN = 1'b1;
    step();
    rstN = 1'b0;
  endtask

  task automatic wr(input logic [7:0] v);
    bus.i_data       = v;
    bus.i_data_valid = 1'b1;
    bus.rd_data      = 1'b0;
    step();
    idle();
  endtask

  task automatic rd();
    bus.rd_data      = 1'b1;
    bus.i_data_valid = 1'b0;
    step();
    idle();
  endtask

  task automatic test_reset();
    bus.i_data       = 8'hFF;
    bus.i_data_valid = 1'b1;
    bus.rd_data      = 1'b1;
    rstN = 1'b1;
    step();
    rstN = 1'b0;
    idle();
    checks++;
    if (bus.o_data !== 25'd0) begin
      errors++;
      $display("FAIL reset_out: got %h want 0", bus.o_data);
    end
    wr(8'h5A);
    checks++;
    if (pix() !== 8'h5A) begin
      errors++;
      $display("FAIL reset_ptrs: got %h want 5a", pix());
    end
  endtask

  task automatic test_fill();
    logic [7:0] e;
    do_reset();
    for (int i = 0; i < W - 1; i++) begin
      wr(8'(i));
    end
    for (int i = 0; i < W - 1; i++) begin
      e = 8'(i);
      checks++;
      if (pix() !== e) begin
        errors++;
        $display("FAIL fill_rd[%0d]: got %h want %h", i, pix(), e);
      end
`ifndef LINE_BUFFER_WINDOW_EN
      checks++;
      if (bus.o_data[24:8] !== 17'd0) begin
        errors++;
        $display("FAIL fill_hi[%0d]: got %h want 0",
                 i, bus.o_data[24:8]);
      end
`endif
      rd();
    end
    checks++;
    if (pix() !== 8'h00) begin
      errors++;
      $display("FAIL fill_last: got %h want 00", pix());
    end
    rd();
    checks++;
    if (pix() !== 8'h00) begin
      errors++;
      $display("FAIL fill_rdwrap: got %h want 00", pix());
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < W + 2; i++) begin
      wr(8'(i));
    end
    wr(8'hC3);
    checks++;
    if (pix() !== 8'(W)) begin
      errors++;
      $display("FAIL wrap_m0: got %h want %h", pix(), 8'(W));
    end
    rd();
    checks++;
    if (pix() !== 8'(W + 1)) begin
      errors++;
      $display("FAIL wrap_m1: got %h want %h", pix(), 8'(W + 1));
    end
    rd();
    checks++;
    if (pix() !== 8'hC3) begin
      errors++;
      $display("FAIL wrap_m2: got %h want c3", pix());
    end
    for (int i = 2; i < W - 1; i++) begin
      rd();
    end
    checks++;
    if (pix() !== 8'hFF) begin
      errors++;
      $display("FAIL wrap_m511: got %h want ff", pix());
    end
    rd();
    checks++;
    if (pix() !== 8'(W)) begin
      errors++;
      $display("FAIL wrap_rd0: got %h want %h", pix(), 8'(W));
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    bus.i_data       = 8'hAA;
    bus.i_data_valid = 1'b1;
    #1;
    checks++;
    if (pix() !== 8'h00) begin
      errors++;
      $display("FAIL same_pre: got %h want 00", pix());
    end
    step();
    idle();
    checks++;
    if (pix() !== 8'hAA) begin
      errors++;
      $display("FAIL same_post: got %h want aa", pix());
    end
    do_reset();
    bus.i_data       = 8'h11;
    bus.i_data_valid = 1'b1;
    bus.rd_data      = 1'b1;
    step();
    idle();
    checks++;
    if (pix() !== 8'h00) begin
      errors++;
      $display("FAIL both_rd: got %h want 00", pix());
    end
    wr(8'h22);
    checks++;
    if (pix() !== 8'h22) begin
      errors++;
      $display("FAIL both_wr: got %h want 22", pix());
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      wr(8'(8'd10 + 8'(i)));
    end
    rd();
    rd();
    rd();
    checks++;
    if (pix() !== 8'd13) begin
      errors++;
      $display("FAIL mid_pre: got %h want 0d", pix());
    end
    do_reset();
    checks++;
    if (bus.o_data !== 25'd0) begin
      errors++;
      $display("FAIL mid_rst: got %h want 0", bus.o_data);
    end
    wr(8'h99);
    checks++;
    if (pix() !== 8'h99) begin
      errors++;
      $display("FAIL mid_wr0: got %h want 99", pix());
    end
    rd();
    checks++;
    if (pix() !== 8'h00) begin
      errors++;
      $display("FAIL mid_cleared: got %h want 00", pix());
    end
  endtask

`ifdef LINE_BUFFER_WINDOW_EN
  task automatic test_window();
    do_reset();
    wr(8'h01);
    wr(8'h02);
    checks++;
    if (bus.o_data !== {1'b0, 8'h01, 8'h02, 8'h00}) begin
      errors++;
      $display("FAIL win_two: got %h want 0010200", bus.o_data);
    end
    wr(8'h03);
    checks++;
    if (bus.o_data !== {1'b1, 8'h01, 8'h02, 8'h03}) begin
      errors++;
      $display("FAIL win_three: got %h want 1010203", bus.o_data);
    end
    rd();
    checks++;
    if (bus.o_data !== {1'b0, 8'h02, 8'h03, 8'h00}) begin
      errors++;
      $display("FAIL win_cons: got %h want 0020300", bus.o_data);
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    rstN   = 1'b0;
    idle();
    #1;
    test_reset();
    test_fill();
    test_wrap();
    test_simultaneous();
    test_mid_reset();
`ifdef LINE_BUFFER_WINDOW_EN
    test_window();
`endif
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
